// File: rtl/multi_counter_sat_pkg.sv
// multi_counter_sat shared types: command opcodes and table-clear FSM states.
// Saturation is selected at build time with MULTI_COUNTER_SAT_EN.
package multi_counter_sat_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INIT = 3'd1,
        OP_INCR = 3'd2,
        OP_DECR = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_QRY  = 3'd6,
        OP_RSV  = 3'd7
    } op_t;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } st_t;

    function automatic logic op_is_cmd(op_t op);
        return (op != OP_NOP) && (op != OP_RSV);
    endfunction

endpackage

// File: rtl/dpsram.sv
// Simple dual-port SRAM: port 0 registered read, port 1 write.
// Read-during-write to the same address returns the old word.
module dpsram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/multi_counter_sat_alu.sv
// Counter execute unit: INIT/INCR/DECR/ADD/SUB/QRY in CNTRS_W+1 bits.
// MULTI_COUNTER_SAT_EN clamps on overflow/underflow, otherwise wraps.
module multi_counter_sat_alu
    import multi_counter_sat_pkg::*;
#(
    parameter int CNTRS_W     = 32,
    parameter int CNTRS_DAT_W = 16
) (
    input  op_t                i_op,
    input  logic [CNTRS_W-1:0] i_dat,
    input  logic [CNTRS_W-1:0] i_val,
    output logic [CNTRS_W-1:0] o_res,
    output logic               o_ovf
);

    logic               w_up;
    logic               w_dn;
    logic               w_init;
    logic [CNTRS_W-1:0] w_opnd;
    logic [CNTRS_W:0]   w_sum;
    logic [CNTRS_W:0]   w_dif;

    always_comb begin
        w_up   = (i_op == OP_INCR) || (i_op == OP_ADD);
        w_dn   = (i_op == OP_DECR) || (i_op == OP_SUB);
        w_init = (i_op == OP_INIT);
        w_opnd = ((i_op == OP_INCR) || (i_op == OP_DECR))
               ? CNTRS_W'(1)
               : CNTRS_W'(i_dat[CNTRS_DAT_W-1:0]);
        w_sum  = {1'b0, i_val} + {1'b0, w_opnd};
        w_dif  = {1'b0, i_val} - {1'b0, w_opnd};
        o_res  = i_val;
        o_ovf  = 1'b0;
        unique case (1'b1)
            w_init: o_res = i_dat;
            w_up: begin
                o_ovf = w_sum[CNTRS_W];
`ifdef MULTI_COUNTER_SAT_EN
                o_res = w_sum[CNTRS_W] ? '1 : w_sum[CNTRS_W-1:0];
`else
                o_res = w_sum[CNTRS_W-1:0];
`endif
            end
            w_dn: begin
                o_ovf = w_dif[CNTRS_W];
`ifdef MULTI_COUNTER_SAT_EN
                o_res = w_dif[CNTRS_W] ? '0 : w_dif[CNTRS_W-1:0];
`else
                o_res = w_dif[CNTRS_W-1:0];
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_counter_sat.sv
// Four-stage counter table with post-reset clear sweep and full forwarding.
// Build with MULTI_COUNTER_SAT_EN for saturating arithmetic.
module multi_counter_sat
    import multi_counter_sat_pkg::*;
#(
    parameter int CNTRS_N     = 256,
    parameter int CNTRS_W     = 32,
    parameter int CNTRS_DAT_W = 16,
    parameter int CNTRS_ID_W  = $clog2(CNTRS_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cntr_pass,
    output logic                  cntr_ready_r,
    input  logic [CNTRS_ID_W-1:0] cntr_id,
    input  op_t                   cntr_op,
    input  logic [CNTRS_W-1:0]    cntr_dat,
    output logic                  status_pass_r,
    output logic                  status_qry_r,
    output logic                  status_ovf_r,
    output logic [CNTRS_ID_W-1:0] status_id_r,
    output logic [CNTRS_W-1:0]    status_dat_r
);

    localparam logic [CNTRS_ID_W-1:0] LAST_ID = CNTRS_ID_W'(CNTRS_N - 1);

    st_t                   r_state;
    st_t                   w_state_nxt;
    logic [CNTRS_ID_W-1:0] r_sweep_addr;
    logic                  w_sweep_we;
    logic                  w_ready_nxt;

    logic                  r_s1_vld;
    logic [CNTRS_ID_W-1:0] r_s1_id;
    op_t                   r_s1_op;
    logic [CNTRS_W-1:0]    r_s1_dat;

    logic                  r_s2_vld;
    logic [CNTRS_ID_W-1:0] r_s2_id;
    op_t                   r_s2_op;
    logic [CNTRS_W-1:0]    r_s2_dat;
    logic                  r_s2_byp;
    logic [CNTRS_W-1:0]    r_s2_byp_dat;

    logic                  r_s3_vld;
    logic [CNTRS_ID_W-1:0] r_s3_id;
    op_t                   r_s3_op;
    logic [CNTRS_W-1:0]    r_s3_dat;
    logic [CNTRS_W-1:0]    r_s3_val;

    logic                  r_s4_vld;
    logic [CNTRS_ID_W-1:0] r_s4_id;
    op_t                   r_s4_op;
    logic [CNTRS_W-1:0]    r_s4_res;
    logic                  r_s4_ovf;

    logic                  w_acc;
    logic                  w_s4_wr;
    logic                  w_coll;
    logic                  w_rd_en;
    logic [CNTRS_W-1:0]    w_rd_data;
    logic [CNTRS_W-1:0]    w_s2_val;
    logic [CNTRS_W-1:0]    w_alu_res;
    logic                  w_alu_ovf;
    logic                  w_wr_en;
    logic [CNTRS_ID_W-1:0] w_wr_addr;
    logic [CNTRS_W-1:0]    w_wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_SWEEP;
            r_sweep_addr <= '0;
            cntr_ready_r <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            cntr_ready_r <= w_ready_nxt;
            if (w_sweep_we)
                r_sweep_addr <= r_sweep_addr + CNTRS_ID_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_SWEEP && r_sweep_addr == LAST_ID)
            w_state_nxt = ST_RUN;
    end

    always_comb begin
        w_sweep_we  = (r_state == ST_SWEEP);
        w_ready_nxt = (r_state == ST_RUN);
    end

    assign w_acc   = cntr_pass & cntr_ready_r & op_is_cmd(cntr_op);
    assign w_s4_wr = r_s4_vld & (r_s4_op != OP_QRY);
    // RAM returns stale data when S4 writes the word S1 reads; take it from S4
    assign w_coll  = w_s4_wr & (r_s4_id == r_s1_id);
    assign w_rd_en = r_s1_vld & (r_s1_op != OP_INIT) & ~w_coll;

    assign w_wr_en   = w_sweep_we | w_s4_wr;
    assign w_wr_addr = w_sweep_we ? r_sweep_addr : r_s4_id;
    assign w_wr_data = w_sweep_we ? '0 : r_s4_res;

    dpsram #(
        .DEPTH (CNTRS_N),
        .WIDTH (CNTRS_W),
        .AW    (CNTRS_ID_W)
    ) u_ram (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_s1_id),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data)
    );

    // Youngest older op on the same id wins
    always_comb begin
        w_s2_val = w_rd_data;
        if (r_s3_vld && r_s3_id == r_s2_id)
            w_s2_val = w_alu_res;
        else if (r_s4_vld && r_s4_id == r_s2_id)
            w_s2_val = r_s4_res;
        else if (r_s2_byp)
            w_s2_val = r_s2_byp_dat;
    end

    multi_counter_sat_alu #(
        .CNTRS_W     (CNTRS_W),
        .CNTRS_DAT_W (CNTRS_DAT_W)
    ) u_alu (
        .i_op  (r_s3_op),
        .i_dat (r_s3_dat),
        .i_val (r_s3_val),
        .o_res (w_alu_res),
        .o_ovf (w_alu_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld     <= 1'b0;
            r_s1_id      <= '0;
            r_s1_op      <= OP_NOP;
            r_s1_dat     <= '0;
            r_s2_vld     <= 1'b0;
            r_s2_id      <= '0;
            r_s2_op      <= OP_NOP;
            r_s2_dat     <= '0;
            r_s2_byp     <= 1'b0;
            r_s2_byp_dat <= '0;
            r_s3_vld     <= 1'b0;
            r_s3_id      <= '0;
            r_s3_op      <= OP_NOP;
            r_s3_dat     <= '0;
            r_s3_val     <= '0;
            r_s4_vld     <= 1'b0;
            r_s4_id      <= '0;
            r_s4_op      <= OP_NOP;
            r_s4_res     <= '0;
            r_s4_ovf     <= 1'b0;
        end else begin
            r_s1_vld     <= w_acc;
            r_s1_id      <= cntr_id;
            r_s1_op      <= cntr_op;
            r_s1_dat     <= cntr_dat;
            r_s2_vld     <= r_s1_vld;
            r_s2_id      <= r_s1_id;
            r_s2_op      <= r_s1_op;
            r_s2_dat     <= r_s1_dat;
            r_s2_byp     <= w_coll;
            r_s2_byp_dat <= r_s4_res;
            r_s3_vld     <= r_s2_vld;
            r_s3_id      <= r_s2_id;
            r_s3_op      <= r_s2_op;
            r_s3_dat     <= r_s2_dat;
            r_s3_val     <= w_s2_val;
            r_s4_vld     <= r_s3_vld;
            r_s4_id      <= r_s3_id;
            r_s4_op      <= r_s3_op;
            r_s4_res     <= w_alu_res;
            r_s4_ovf     <= w_alu_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_pass_r <= 1'b0;
            status_qry_r  <= 1'b0;
            status_ovf_r  <= 1'b0;
            status_id_r   <= '0;
            status_dat_r  <= '0;
        end else begin
            status_pass_r <= r_s4_vld;
            if (r_s4_vld) begin
                status_qry_r <= (r_s4_op == OP_QRY);
                status_ovf_r <= r_s4_ovf;
                status_id_r  <= r_s4_id;
                status_dat_r <= r_s4_res;
            end
        end
    end

endmodule

// File: doc/multi_counter_sat.md
# multi_counter_sat

Parametrised successor to the team's four-stage multi-counter: a table of `CNTRS_N` independent `CNTRS_W`-bit counters held in a dual-port SRAM. It accepts one command per cycle with valid/ready flow control and emits one status beat per command. New behaviour:

- arbitrary add/subtract operands;
- overflow/underflow reporting;
- optional saturation;
- a hardware clear sweep after reset, so the table never holds X.

It sits between a command source (stats/event logic) and a status consumer with no back-pressure.

## Interface
- `CNTRS_N`, 256, number of counters (≥2)
- `CNTRS_W`, 32, counter width
- `CNTRS_DAT_W`, 16, ADD/SUB operand width (≤ `CNTRS_W`; INIT uses full `CNTRS_W`)
- `CNTRS_ID_W`, `$clog2(CNTRS_N)`, derived id width, not overridden
- `clk`  in  1  single clock, all logic posedge
- `rst`  in  1  reset, asynchronous and active-low
- `cntr_pass`  in  1  command valid
- `cntr_ready_r`  out  1  command ready; transfer when `cntr_pass & cntr_ready_r`
- `cntr_id`  in  `CNTRS_ID_W`  counter index
- `cntr_op`  in  3  `multi_counter_sat_pkg::op_t`
- `cntr_dat`  in  `CNTRS_W`  INIT value; low `CNTRS_DAT_W` bits are the ADD/SUB operand
- `status_pass_r`  out  1  status beat valid
- `status_qry_r`  out  1  beat is a QRY response
- `status_ovf_r`  out  1  result overflowed/underflowed
- `status_id_r`  out  `CNTRS_ID_W`  counter index
- `status_dat_r`  out  `CNTRS_W`  post-op counter value

## Operation
- Ops: NOP=0, INIT=1 (load `cntr_dat`), INCR=2, DECR=3, ADD=4 (+ zero-extended operand), SUB=5 (− zero-extended operand), QRY=6 (read only, no write), 7 reserved (treated as NOP).
- NOP/reserved transfers are dropped and emit no status.
- All other ops emit exactly one status beat carrying the post-op value.
- FSM states:
  - SWEEP: entered on reset. `cntr_ready_r`=0; writes 0 to address 0..`CNTRS_N`-1, one per cycle via the write port; 9-bit-style address counter sized `CNTRS_ID_W`.
  - RUN: entered when the sweep writes address `CNTRS_N`-1. `cntr_ready_r`=1 permanently.
  - There is no other exit from RUN.
- Pipeline stages:
  - S1: RAM read, skipped for INIT.
  - S2: data capture.
  - S3: execute.
  - S4: writeback + status; QRY does not write back.
- Forwarding is mandatory:
  - S4→S2, S3→S2, S4→S3 on id match.
  - S1/S4 same-address collision is resolved by suppressing the read and bypassing S4 data.
  - Result: any op sequence on one id, back-to-back, behaves as if serialised.
- Arithmetic: computed in `CNTRS_W+1` bits.
  - `status_ovf_r`=1 on carry out (INCR/ADD) or borrow (DECR/SUB).
  - INIT/QRY always 0.
- Reset mid-operation: in-flight commands are discarded, no status emitted, and the sweep restarts from address 0.

## Timing
- Reset values: `cntr_ready_r`=0, `status_pass_r`=0, `status_qry_r`=0, `status_ovf_r`=0, `status_id_r`=0, `status_dat_r`=0.
- Sweep duration: `cntr_ready_r` rises `CNTRS_N` cycles after the first clk edge following `rst` deassertion.
- Latency: command transferred at edge E0 → status registered at E4.
- Throughput: one command per cycle, no bubbles, including same-id streams.
- Status is fire-and-forget and valid for exactly one cycle per beat.
- The status fields hold their last value when `status_pass_r`=0.
- Commands presented while `cntr_ready_r`=0 are ignored; the source must hold them.

## Configuration
- `MULTI_COUNTER_SAT_EN` defined:
  - Overflowing INCR/ADD clamps to all-ones.
  - Underflowing DECR/SUB clamps to 0.
  - `status_ovf_r`=1 flags the clamp.
- Undefined: results wrap modulo 2^`CNTRS_W`; `status_ovf_r`=1 flags the wrap.
- The flag semantics are identical in both builds; only `status_dat_r` and the stored value differ.

## Structure
- `multi_counter_sat_pkg` holds:
  - `op_t` (3-bit enum) and per-op encodings;
  - the FSM state enum (SWEEP, RUN).
- Sub-module `multi_counter_sat_alu`, purely combinational:
  - inputs: op, operand, forwarded value;
  - outputs: result, ovf;
  - contains the saturation `ifdef`.
- Table storage reuses the existing `dpsram` (port 0 read, port 1 write). The sweep muxes onto port 1.

## Test plan
- Reset release, `CNTRS_N`=256 → `cntr_ready_r` low exactly 256 cycles; then QRY id 5 → status_dat 0, qry=1, ovf=0 at E4.
- INIT id 3 =10, then INCR, INCR, DECR, QRY on id 3 back-to-back → status_dat 10, 11, 12, 11, 11 on consecutive cycles.
- INIT id 7 =0xFFFF_FFFE, then ADD 5 → SAT_EN: dat 0xFFFF_FFFF, ovf=1; without: dat 3, ovf=1.
- INIT id 9 =2, then SUB 3 → SAT_EN: dat 0, ovf=1; without: 0xFFFF_FFFF, ovf=1.
- Interleave ids 1,2,1,2 INCR from 0 with NOP and reserved op 7 inserted → only INCR beats emitted; values 1,1,2,2.
- Assert `rst` with 3 commands in flight → no further status beats, sweep restarts, all counters read 0 afterwards.
